// File: rtl/text_line_buffer.sv
// Single-line text buffer: characters are appended or backspaced from the write side
// while a VGA scan reads the cell under the beam with one cycle of latency.
module text_line_buffer #(
  parameter int unsigned MAX_CHARS  = 16,
  parameter int unsigned SCALE      = 1,
  parameter int unsigned ORIGIN_ROW = 0,
  parameter int unsigned ORIGIN_COL = 0
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           wr_valid,
  input  logic [7:0]                     wr_char,
  output logic                           wr_ready,
  input  logic                           clear,
  output logic                           busy,
  output logic [$clog2(MAX_CHARS+1)-1:0] length,
  input  logic [9:0]                     VGA_row,
  input  logic [9:0]                     VGA_col,
  output logic [7:0]                     character,
  output logic                           in_region
);

  localparam int unsigned LW     = $clog2(MAX_CHARS + 1);
  localparam int unsigned IW     = $clog2(MAX_CHARS);
  localparam int unsigned CELL_W = 6 * SCALE;
  localparam int unsigned LINE_W = CELL_W * MAX_CHARS;
  localparam logic [7:0]  SPACE     = 8'h20;
  localparam logic [7:0]  BACKSPACE = 8'h08;

  typedef enum logic [1:0] {CLEAR, READY, FULL} state_t;

  state_t          state, next_state;
  logic [IW-1:0]   clr_idx, next_idx;
  logic [LW-1:0]   next_len, len_m1;
  logic [7:0]      cells [MAX_CHARS];

  logic            mem_we;
  logic [IW-1:0]   mem_addr;
  logic [7:0]      mem_data;

  logic [31:0]     row_off, col_off;
  logic [IW-1:0]   rd_idx;
  logic            rd_hit;
  logic [7:0]      rd_char;

  assign busy     = (state == CLEAR);
  assign wr_ready = (state == READY) || ((state == FULL) && (wr_char == BACKSPACE));
  assign len_m1   = length - LW'(1);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state   <= CLEAR;
      clr_idx <= '0;
      length  <= '0;
    end else begin
      state   <= next_state;
      clr_idx <= next_idx;
      length  <= next_len;
    end
  end

  // Clear has priority over any write presented in the same cycle.
  always_comb begin
    next_state = state;
    next_idx   = clr_idx;
    next_len   = length;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = SPACE;
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_idx;
        if (clear) begin
          next_idx = '0;
        end else if (clr_idx == IW'(MAX_CHARS - 1)) begin
          next_state = READY;
          next_idx   = '0;
          next_len   = '0;
        end else begin
          next_idx = clr_idx + IW'(1);
        end
      end
      READY, FULL: begin
        if (clear) begin
          next_state = CLEAR;
          next_idx   = '0;
          next_len   = '0;
        end else if (wr_valid && wr_ready) begin
          if (wr_char == BACKSPACE) begin
            if (length != '0) begin
              next_len   = len_m1;
              mem_we     = 1'b1;
              mem_addr   = len_m1[IW-1:0];
              next_state = READY;
            end
          end else begin
            mem_we   = 1'b1;
            mem_addr = length[IW-1:0];
            mem_data = wr_char;
            next_len = length + LW'(1);
            if (length == LW'(MAX_CHARS - 1)) begin
              next_state = FULL;
            end
          end
        end
      end
      default: begin
        next_state = CLEAR;
        next_idx   = '0;
        next_len   = '0;
      end
    endcase
    if (!rst_l) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      cells[mem_addr] <= mem_data;
    end
  end

  // Offsets wrap to huge values when the scan is above/left of the origin,
  // so a single upper-bound compare covers both edges of the box.
  always_comb begin
    row_off = 32'(VGA_row) - ORIGIN_ROW;
    col_off = 32'(VGA_col) - ORIGIN_COL;
    rd_hit  = (row_off < CELL_W) && (col_off < LINE_W);
    rd_idx  = IW'(col_off / CELL_W);
    rd_char = SPACE;
    if (rd_hit) begin
      rd_char = cells[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      character <= SPACE;
      in_region <= 1'b0;
    end else begin
      character <= rd_char;
      in_region <= rd_hit;
    end
  end

endmodule

// File: tb/tb_text_line_buffer.sv
// Directed bench for text_line_buffer: reset sweep, append/backspace, full line,
// clear interactions and read-side region boundaries.
module tb_text_line_buffer;

  localparam int MAX_CHARS  = 16;
  localparam int SCALE      = 1;
  localparam int ORIGIN_ROW = 50;
  localparam int ORIGIN_COL = 100;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;
  logic       clear;
  logic       busy;
  logic [4:0] length;
  logic [9:0] VGA_row;
  logic [9:0] VGA_col;
  logic [7:0] character;
  logic       in_region;

  int assert_count = 0;
  int fail_count   = 0;
  int n;

  always #5 clk = ~clk;

  text_line_buffer #(
    .MAX_CHARS (MAX_CHARS),
    .SCALE     (SCALE),
    .ORIGIN_ROW(ORIGIN_ROW),
    .ORIGIN_COL(ORIGIN_COL)
  ) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .wr_valid (wr_valid),
    .wr_char  (wr_char),
    .wr_ready (wr_ready),
    .clear    (clear),
    .busy     (busy),
    .length   (length),
    .VGA_row  (VGA_row),
    .VGA_col  (VGA_col),
    .character(character),
    .in_region(in_region)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [7:0] c, input logic clr);
    wr_valid = v;
    wr_char  = c;
    clear    = clr;
    tick();
    wr_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic read_cell(input int k, input logic [7:0] exp, input string tag);
    VGA_row = 10'(ORIGIN_ROW + 2);
    VGA_col = 10'(ORIGIN_COL + 6 * k);
    tick();
    check_output(tag, 32'(character), 32'(exp));
  endtask

  task automatic set_scan(input int r, input int c);
    VGA_row = 10'(r);
    VGA_col = 10'(c);
    tick();
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_l    = 1'b0;
    wr_valid = 1'b0;
    wr_char  = 8'h00;
    clear    = 1'b0;
    VGA_row  = 10'd52;
    VGA_col  = 10'd106;
    repeat (3) tick();
    check_output("rst_character", 32'(character), 32'h20);
    check_output("rst_in_region", 32'(in_region), 32'h0);
    check_output("rst_length", 32'(length), 32'h0);
    check_output("rst_wr_ready", 32'(wr_ready), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h1);

    rst_l = 1'b1;
    for (int i = 0; i < MAX_CHARS; i++) begin
      check_output($sformatf("sweep_busy_%0d", i), 32'(busy), 32'h1);
      tick();
    end
    check_output("sweep_done_busy", 32'(busy), 32'h0);
    check_output("sweep_done_ready", 32'(wr_ready), 32'h1);
    check_output("sweep_done_length", 32'(length), 32'h0);
    read_cell(0, 8'h20, "blank_cell0");
    read_cell(15, 8'h20, "blank_cell15");

    apply_stimulus(1'b1, 8'h41, 1'b0);
    apply_stimulus(1'b1, 8'h42, 1'b0);
    check_output("ab_length", 32'(length), 32'h2);
    set_scan(52, 106);
    check_output("ab_char_cell1", 32'(character), 32'h42);
    check_output("ab_in_region", 32'(in_region), 32'h1);
    set_scan(55, 100);
    check_output("bottom_row_char", 32'(character), 32'h41);
    check_output("bottom_row_in", 32'(in_region), 32'h1);
    set_scan(56, 100);
    check_output("below_row_in", 32'(in_region), 32'h0);
    check_output("below_row_char", 32'(character), 32'h20);
    set_scan(49, 100);
    check_output("above_row_in", 32'(in_region), 32'h0);
    set_scan(52, 99);
    check_output("left_col_in", 32'(in_region), 32'h0);
    set_scan(52, 195);
    check_output("last_col_in", 32'(in_region), 32'h1);
    check_output("last_col_char", 32'(character), 32'h20);
    set_scan(52, 196);
    check_output("past_end_in", 32'(in_region), 32'h0);
    check_output("past_end_char", 32'(character), 32'h20);

    for (int i = 0; i < 14; i++) apply_stimulus(1'b1, 8'(8'h43 + i), 1'b0);
    check_output("full_length", 32'(length), 32'd16);
    wr_char = 8'h41;
    #1;
    check_output("full_ready_char", 32'(wr_ready), 32'h0);
    apply_stimulus(1'b1, 8'h5A, 1'b0);
    check_output("full_write_dropped", 32'(length), 32'd16);
    wr_char = 8'h08;
    #1;
    check_output("full_ready_bs", 32'(wr_ready), 32'h1);
    read_cell(15, 8'h50, "full_cell15");
    apply_stimulus(1'b1, 8'h08, 1'b0);
    check_output("bs_length", 32'(length), 32'd15);
    wr_char = 8'h41;
    #1;
    check_output("bs_ready", 32'(wr_ready), 32'h1);
    read_cell(15, 8'h20, "bs_cell15");
    read_cell(14, 8'h4F, "bs_cell14");

    for (int i = 0; i < 15; i++) apply_stimulus(1'b1, 8'h08, 1'b0);
    check_output("empty_length", 32'(length), 32'h0);
    apply_stimulus(1'b1, 8'h08, 1'b0);
    check_output("bs_at_zero_length", 32'(length), 32'h0);
    read_cell(0, 8'h20, "bs_at_zero_cell0");
    read_cell(1, 8'h20, "bs_at_zero_cell1");

    VGA_row  = 10'd52;
    VGA_col  = 10'd100;
    wr_valid = 1'b1;
    wr_char  = 8'h51;
    tick();
    wr_valid = 1'b0;
    check_output("rw_same_cell_old", 32'(character), 32'h20);
    tick();
    check_output("rw_same_cell_new", 32'(character), 32'h51);
    check_output("rw_length", 32'(length), 32'h1);

    VGA_col = 10'd106;
    apply_stimulus(1'b1, 8'h52, 1'b1);
    check_output("clr_busy", 32'(busy), 32'h1);
    tick();
    check_output("clr_write_dropped", 32'(character), 32'h20);
    wait_idle(n);
    check_output("clr_sweep_cycles", 32'(n + 1), 32'd16);
    check_output("clr_length", 32'(length), 32'h0);
    check_output("clr_ready", 32'(wr_ready), 32'h1);
    read_cell(0, 8'h20, "clr_cell0");

    apply_stimulus(1'b0, 8'h00, 1'b1);
    repeat (5) tick();
    apply_stimulus(1'b0, 8'h00, 1'b1);
    wait_idle(n);
    check_output("restart_sweep_cycles", 32'(n), 32'd16);

    apply_stimulus(1'b1, 8'h41, 1'b0);
    apply_stimulus(1'b1, 8'h42, 1'b0);
    VGA_row  = 10'd52;
    VGA_col  = 10'd106;
    rst_l    = 1'b0;
    wr_valid = 1'b1;
    wr_char  = 8'h43;
    tick();
    check_output("midrst_length", 32'(length), 32'h0);
    check_output("midrst_busy", 32'(busy), 32'h1);
    check_output("midrst_wr_ready", 32'(wr_ready), 32'h0);
    check_output("midrst_in_region", 32'(in_region), 32'h0);
    check_output("midrst_character", 32'(character), 32'h20);
    rst_l    = 1'b1;
    wr_valid = 1'b0;
    wait_idle(n);
    check_output("midrst_sweep_cycles", 32'(n), 32'd16);
    read_cell(0, 8'h20, "midrst_cell0");
    read_cell(1, 8'h20, "midrst_cell1");
    read_cell(2, 8'h20, "midrst_cell2");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/text_line_buffer.md
TEXT_LINE_BUFFER -- requirements
Module: text_line_buffer

Interface
REQ-001 SHALL have parameter MAX_CHARS, default 16: number of character cells in the line, range 2..64.
REQ-002 SHALL have parameter SCALE, default 1: pixel scale, so each cell is 6*SCALE pixels square.
REQ-003 SHALL have parameter ORIGIN_ROW, default 0: VGA row of the top edge of the line.
REQ-004 SHALL have parameter ORIGIN_COL, default 0: VGA column of the left edge of cell 0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_l, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port wr_valid, input, 1 bit: wr_char is presented this cycle.
REQ-008 SHALL have port wr_char, input, 8 bits: ASCII code to append; 8'h08 means backspace.
REQ-009 SHALL have port wr_ready, output, 1 bit: buffer accepts wr_char this cycle.
REQ-010 SHALL have port clear, input, 1 bit: single-cycle request to blank the whole line.
REQ-011 SHALL have port busy, output, 1 bit: a clear sweep is in progress.
REQ-012 SHALL have port length, output, $clog2(MAX_CHARS+1) bits: number of committed characters.
REQ-013 SHALL have port VGA_row, input, 10 bits: current scan row.
REQ-014 SHALL have port VGA_col, input, 10 bits: current scan column.
REQ-015 SHALL have port character, output, 8 bits: code for the cell under the scan position, to be rendered.
REQ-016 SHALL have port in_region, output, 1 bit: scan position lies inside the line's bounding box.

Function
REQ-017 SHALL implement an FSM with states CLEAR, READY and FULL.
REQ-018 In CLEAR, SHALL write 8'h20 (space) to one cell per cycle, indices 0..MAX_CHARS-1, hold busy=1 and wr_ready=0, then enter READY with length=0.
REQ-019 A CLEAR sweep SHALL take exactly MAX_CHARS cycles; busy SHALL drop on the cycle READY is entered.
REQ-020 A write SHALL be accepted only on a cycle with wr_valid && wr_ready.
REQ-021 An accepted non-backspace write SHALL store wr_char at index length and increment length.
REQ-022 When length reaches MAX_CHARS, the FSM SHALL enter FULL.
REQ-023 An accepted backspace with length>0 SHALL decrement length, write 8'h20 at the new index, and return from FULL to READY.
REQ-024 An accepted backspace with length==0 SHALL change nothing.
REQ-025 wr_ready SHALL be 1 in READY, and 1 in FULL only when wr_char==8'h08; otherwise 0.
REQ-026 clear asserted in READY or FULL SHALL enter CLEAR next cycle; a write in the same cycle SHALL be dropped.
REQ-027 clear asserted during CLEAR SHALL restart the sweep at index 0.
REQ-028 Read side, in_region condition: ORIGIN_ROW <= VGA_row < ORIGIN_ROW+6*SCALE and ORIGIN_COL <= VGA_col < ORIGIN_COL+6*SCALE*MAX_CHARS.
REQ-029 Read side, cell index: (VGA_col-ORIGIN_COL)/(6*SCALE).
REQ-030 character and in_region SHALL be registered, with 1-cycle latency from VGA_row/VGA_col.
REQ-031 character SHALL be 8'h20 when out of region.
REQ-032 A read and write to the same cell in the same cycle SHALL return the old value.
REQ-033 The read side SHALL operate in every state; during CLEAR it SHALL return cell contents as currently swept.

Reset
REQ-034 On a clk edge with rst_l=0, outputs SHALL be: character=8'h20, in_region=0, length=0, wr_ready=0, busy=1.
REQ-035 On reset, the FSM SHALL enter CLEAR at index 0.
REQ-036 After rst_l rises, the line SHALL be fully blank after MAX_CHARS cycles.
REQ-037 Reset asserted mid-write or mid-sweep SHALL abandon the operation.

Verification
REQ-038 Reset release, MAX_CHARS=16: busy=1 for 16 cycles, then busy=0, wr_ready=1, length=0.
REQ-039 Write "AB" (8'h41, 8'h42) with SCALE=1, ORIGIN_COL=100, ORIGIN_ROW=50; drive VGA_row=52, VGA_col=106: one cycle later character=8'h42, in_region=1.
REQ-040 Write 16 characters: length=16, FULL, wr_ready=0 for 8'h41; then backspace: length=15, cell 15=8'h20, wr_ready=1.
REQ-041 Backspace at length=0: length stays 0, all cells unchanged.
REQ-042 clear coincident with a wr_valid write: write dropped, busy=1 next cycle, length=0 after sweep.
REQ-043 VGA_col=ORIGIN_COL+96 with SCALE=1, MAX_CHARS=16 (one past the last cell): in_region=0, character=8'h20.
